ingress_frame_arbiter: RTL

Frame-granular round-robin arbiter that shares the single parser ingress (frame_control_fsm plus header path) among NUM_PORTS AXI-Stream input ports. It grants one port at a time and holds the grant until that frame's tlast beat is accepted. It enforces a MAX_BEATS frame-length limit by truncating oversize frames (forced tlast, error flag) and discarding their remainder. It sits directly in front of the parser and drives the parser's beat_accept/tlast inputs through its master stream.

---
 rtl/ingress_arb_pkg.sv | 14 +
 rtl/rr_priority_picker.sv | 37 +++
 rtl/ingress_frame_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ingress_arb_pkg.sv
// Shared types and constants for the ingress frame arbiter.
//   arb_state_e  : arbiter FSM states (IDLE, PASS, DROP)
//   TRUNC_CNT_W  : width of the saturating truncated-frame counter
package ingress_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } arb_state_e;

    localparam int TRUNC_CNT_W = 16;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: purely combinational rotate-and-encode.
// Starting at index ptr and scanning ptr, ptr+1, ... (mod NUM_PORTS),
// selects the first asserted request.
//   req     : request vector, one bit per port
//   ptr     : highest-priority index this round (must be < NUM_PORTS)
//   any_req : at least one request is asserted
//   sel     : index of the selected requester (0 when any_req is low)
module rr_priority_picker #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    ptr,
    output logic                 any_req,
    output logic [PORT_W-1:0]    sel
);

    int idx;

    // Scan from the farthest offset back to offset 0 so the nearest
    // requester after ptr is written last and wins.
    always_comb begin
        any_req = |req;
        sel     = '0;
        idx     = 0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (req[idx[PORT_W-1:0]]) begin
                sel = idx[PORT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ingress_frame_arbiter.sv
// Frame-granular round-robin arbiter in front of the parser ingress.
// One input port is granted per frame; the grant is held until the frame's
// tlast beat is accepted. Frames longer than MAX_BEATS are cut: the beat
// numbered MAX_BEATS is forwarded with forced tlast and tuser=1, and the
// rest of the frame is swallowed.
//   s_tdata/s_tvalid/s_tlast/s_tready : NUM_PORTS slave streams
//   m_tdata/m_tvalid/m_tlast/m_tuser/m_tid/m_tready : master stream
//   busy        : a frame is being passed or dropped
//   trunc_count : saturating count of truncated frames
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high; the master stream is a zero-latency combinational path from the
// granted port, so m_tready feeds s_tready[grant] directly.
module ingress_frame_arbiter
    import ingress_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 64,
    parameter int MAX_BEATS = 256,
    parameter int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS*DATA_W-1:0] s_tdata,
    input  logic [NUM_PORTS-1:0]        s_tvalid,
    input  logic [NUM_PORTS-1:0]        s_tlast,
    output logic [NUM_PORTS-1:0]        s_tready,
    output logic [DATA_W-1:0]           m_tdata,
    output logic                        m_tvalid,
    output logic                        m_tlast,
    output logic                        m_tuser,
    output logic [PORT_W-1:0]           m_tid,
    input  logic                        m_tready,
    output logic                        busy,
    output logic [TRUNC_CNT_W-1:0]      trunc_count
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    arb_state_e             state_q;
    logic [PORT_W-1:0]      grant_q;
    logic [PORT_W-1:0]      rr_ptr_q;
    logic [PORT_W-1:0]      rr_ptr_d;
    logic [CNT_W-1:0]       beat_cnt_q;
    logic [TRUNC_CNT_W-1:0] trunc_q;
    logic [TRUNC_CNT_W-1:0] trunc_d;

    logic                   any_req;
    logic [PORT_W-1:0]      pick_sel;
    logic                   g_valid;
    logic                   g_last;
    logic                   at_limit;
    logic                   accept;

    rr_priority_picker #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_picker (
        .req     (s_tvalid),
        .ptr     (rr_ptr_q),
        .any_req (any_req),
        .sel     (pick_sel)
    );

    assign g_valid  = s_tvalid[grant_q];
    assign g_last   = s_tlast[grant_q];
    // beat_cnt counts beats already accepted, so the beat now on the bus is
    // number MAX_BEATS when MAX_BEATS-1 have gone before it.
    assign at_limit = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
    assign accept   = (state_q == PASS) && g_valid && m_tready;

    // Next round starts just after the port that finished its frame.
    always_comb begin
        rr_ptr_d = '0;
        if (NUM_PORTS > 1 && grant_q != PORT_W'(NUM_PORTS - 1)) begin
            rr_ptr_d = grant_q + 1'b1;
        end
    end

    assign trunc_d = (&trunc_q) ? trunc_q : trunc_q + 1'b1;

    always_comb begin
        s_tready = '0;
        if (state_q == PASS) begin
            s_tready[grant_q] = m_tready;
        end else if (state_q == DROP) begin
            s_tready[grant_q] = 1'b1;
        end
    end

    assign m_tvalid    = (state_q == PASS) && g_valid;
    assign m_tlast     = m_tvalid && (g_last || at_limit);
    assign m_tuser     = m_tvalid && !g_last && at_limit;
    assign m_tdata     = s_tdata[grant_q*DATA_W +: DATA_W];
    assign m_tid       = grant_q;
    assign busy        = (state_q != IDLE);
    assign trunc_count = trunc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            trunc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q    <= pick_sel;
                        beat_cnt_q <= '0;
                        state_q    <= PASS;
                    end
                end
                PASS: begin
                    if (accept) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (g_last) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= rr_ptr_d;
                        end else if (at_limit) begin
                            trunc_q <= trunc_d;
                            state_q <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (g_valid && g_last) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
